// File: rtl/uart_core_if.sv
// Handshake bundle between host logic and uart_core.
//   tx_data/tx_valid/tx_ready : host -> UART transmit word, valid/ready handshake
//   rx_data/rx_valid/rx_ready : UART -> host received word, valid/ready handshake
//   rx_parity_err/rx_frame_err/rx_overrun : single-cycle error pulses from the receiver
// The master modport is the host side; the slave modport is the UART side.
interface uart_core_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_core.sv
// Single-clock UART with independent TX and RX engines paced by internal bit counters.
//   clk : system clock
//   rst : asynchronous active-low reset (deassertion synchronised internally)
//   bus : uart_core_if slave modport (TX/RX handshakes and RX error pulses)
//   tx  : serial output, idle high
//   rx  : serial input, asynchronous to clk
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
module uart_core #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned INPUT_CLK = 27000000,
  parameter int unsigned UART_CLK  = 1000000,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_core_if.slave bus,
  output logic       tx,
  input  logic       rx
);
  localparam int unsigned ClksPerBit = INPUT_CLK / UART_CLK;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(ClksPerBit / 2 - 1);
  localparam logic [3:0] DataLast  = 4'(DATA_BITS - 1);
  localparam logic [3:0] StopLast  = 4'(STOP_BITS - 1);
  localparam bit         HasParity = (PARITY != 0);
  localparam bit         OddParity = (PARITY == 2);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  // Reset: assert immediately, release two clocks after rst rises.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  // ---------------------------------------------------------------- TX engine
  tx_state_e            tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_cnt_last;

  assign tx_cnt_last = (tx_cnt_q == CntLast);

  // tx_d is the line level for the bit the FSM enters on this edge, so tx is glitch-free.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_last ? '0 : tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (bus.tx_valid) begin
          tx_state_d = TxStart;
          tx_shift_d = bus.tx_data;
          tx_par_d   = (^bus.tx_data) ^ OddParity;
          tx_d       = 1'b0;
        end
      end
      TxStart: begin
        if (tx_cnt_last) begin
          tx_state_d = TxData;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
        end
      end
      TxData: begin
        if (tx_cnt_last) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == DataLast) begin
            tx_bit_d = '0;
            if (HasParity) begin
              tx_state_d = TxParity;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = TxStop;
              tx_d       = 1'b1;
            end
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_d     = tx_shift_q[1];
          end
        end
      end
      TxParity: begin
        if (tx_cnt_last) begin
          tx_state_d = TxStop;
          tx_bit_d   = '0;
          tx_d       = 1'b1;
        end
      end
      TxStop: begin
        if (tx_cnt_last) begin
          if (tx_bit_q == StopLast) tx_state_d = TxIdle;
          else                      tx_bit_d   = tx_bit_q + 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  assign tx           = tx_q;
  assign bus.tx_ready = (tx_state_q == TxIdle);

  // ---------------------------------------------------------------- RX engine
  rx_state_e            rx_state_q, rx_state_d;
  logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_done_q, rx_done_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic                 rx_cnt_last;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ppulse_q, rx_ppulse_d;
  logic                 rx_fpulse_q, rx_fpulse_d;
  logic                 rx_ovr_q, rx_ovr_d;
  logic                 rx_good, rx_deliver;

  assign rx_cnt_last = (rx_cnt_q == CntLast);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_last ? '0 : rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_done_d  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RxStart;
          rx_perr_d  = 1'b0;
          rx_ferr_d  = 1'b0;
        end
      end
      RxStart: begin
        // Mid-point of the start bit; a high level here was only a glitch.
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_last) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DataLast) begin
            rx_bit_d   = '0;
            rx_state_d = HasParity ? RxParity : RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
      RxParity: begin
        if (rx_cnt_last) begin
          rx_perr_d  = rx_sync_q ^ (^rx_shift_q) ^ OddParity;
          rx_bit_d   = '0;
          rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_cnt_last) begin
          if (!rx_sync_q) rx_ferr_d = 1'b1;
          if (rx_bit_q == StopLast) begin
            rx_state_d = RxIdle;
            rx_done_d  = 1'b1;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Completion one cycle after the last stop sample: frame > parity > overrun > deliver.
  always_comb begin
    rx_good     = rx_done_q && !rx_ferr_q && !rx_perr_q;
    rx_fpulse_d = rx_done_q && rx_ferr_q;
    rx_ppulse_d = rx_done_q && !rx_ferr_q && rx_perr_q;
    rx_ovr_d    = rx_good && rx_valid_q && !bus.rx_ready;
    rx_deliver  = rx_good && !rx_ovr_d;
    rx_data_d   = rx_deliver ? rx_shift_q : rx_data_q;
    rx_valid_d  = rx_valid_q;
    if (rx_deliver)                     rx_valid_d = 1'b1;
    else if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_perr_q   <= 1'b0;
      rx_ferr_q   <= 1'b0;
      rx_done_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ppulse_q <= 1'b0;
      rx_fpulse_q <= 1'b0;
      rx_ovr_q    <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_perr_q   <= rx_perr_d;
      rx_ferr_q   <= rx_ferr_d;
      rx_done_q   <= rx_done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_ppulse_q <= rx_ppulse_d;
      rx_fpulse_q <= rx_fpulse_d;
      rx_ovr_q    <= rx_ovr_d;
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_parity_err = rx_ppulse_q;
  assign bus.rx_frame_err  = rx_fpulse_q;
  assign bus.rx_overrun    = rx_ovr_q;
endmodule
